sweep_checker: RTL and testbench
================================

Name: sweep_checker

Overview:
Parametrised exhaustive-stimulus engine for small combinational DUTs. It drives every WIDTH-bit input vector in ascending order, holds each vector for HOLD cycles, and samples the DUT's 1-bit response on the last hold cycle. It compares the sample against a parameter truth table, then reports error count, first failing vector and a pass flag. It replaces hand-written per-vector stimulus in unit benches and can also sit on-chip as a self-test for small logic functions.

Parameters:
WIDTH, 2, number of DUT input bits; sweep covers 0 .. 2**WIDTH-1 (legal 1..8)
HOLD, 4, cycles each vector is held before sampling (legal >= 1)
TRUTH, 4'b0110, expected DUT output; bit k is the expected value for vector k; width 2**WIDTH
ERRW, 8, width of the error counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
stop_on_err  input  1  1 = end the sweep at the first mismatch; sampled with start
dut_out  input  1  DUT response to vec
vec  output  WIDTH  current stimulus vector to the DUT
busy  output  1  sweep in progress
done  output  1  sweep finished; sticky until start or rst
pass  output  1  done and zero errors
err_count  output  ERRW  mismatches seen, saturating
first_err_valid  output  1  at least one mismatch recorded
first_err_vec  output  WIDTH  vector of the first mismatch

Behaviour:
- Reset (rst=1 at an edge, regardless of state): state=IDLE and all outputs 0. Mid-sweep reset aborts immediately, with no partial results retained.
- States: IDLE, RUN, DONE; internal hold_cnt (0..HOLD-1) and latched stop mode.
- IDLE: start=1 -> RUN next cycle with vec=0, hold_cnt=0, busy=1, and the stop_on_err value latched.
- DONE: done=1, busy=0, and all results held. start=1 -> RUN with err_count, first_err_*, done and pass cleared, vec=0.
- RUN: start is ignored. Each edge with hold_cnt<HOLD-1 increments hold_cnt. The edge with hold_cnt==HOLD-1 is the sample edge:
  - mismatch = dut_out != TRUTH[vec];
  - on mismatch, err_count increments, saturating at 2**ERRW-1;
  - on the first mismatch of the sweep, first_err_vec=vec and first_err_valid=1;
  - if mismatch and latched stop mode -> DONE, with vec held at the failing vector;
  - else if vec==2**WIDTH-1 -> DONE, with vec held at the final vector, no wrap;
  - else vec=vec+1 and hold_cnt=0.
- HOLD=1: vec advances every cycle and each edge is a sample edge.
- Latency: a full sweep keeps busy=1 for exactly 2**WIDTH*HOLD cycles. done and pass rise on the cycle after the final sample edge.
- pass is registered: 1 only in DONE with err_count==0. It is never 1 while busy.
- rst has priority over start on the same edge.

Test Plan:
- WIDTH=2, HOLD=4, TRUTH=0110, XOR DUT, start pulse -> vec 0,1,2,3 for 4 cycles each; busy high 16 cycles; then done=1, pass=1, err_count=0, first_err_valid=0.
- Same setup, DUT stuck-at-0, stop_on_err=0 -> err_count=2, first_err_vec=1, first_err_valid=1, pass=0, vec=3 in DONE.
- Stuck-at-0 DUT, stop_on_err=1 -> busy for 8 cycles; DONE with vec=1, err_count=1, first_err_vec=1, pass=0.
- rst for one cycle while vec=2 mid-hold -> next cycle all outputs 0 and state IDLE. A new start then runs a full 16-cycle sweep with pass=1.
- start held high throughout RUN -> no restart, sweep completes normally. start in DONE -> results cleared the next cycle and vec=0, busy=1.
- WIDTH=4, HOLD=1, ERRW=2, TRUTH=all-ones, DUT tied to 0 -> err_count saturates at 3, first_err_vec=0, busy for 16 cycles, pass=0.

Source files
------------

// File: rtl/sweep_checker_if.sv
// Bundle between the sweep engine and its controller/DUT side.
// The engine (master) drives the stimulus and the results; the other side drives start/mode/response.
interface sweep_checker_if #(
  parameter int WIDTH = 2,
  parameter int ERRW  = 8
);
  logic             start;
  logic             stop_on_err;
  logic             dut_out;
  logic [WIDTH-1:0] vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERRW-1:0]  err_count;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_vec;

  modport master (
    input  start, stop_on_err, dut_out,
    output vec, busy, done, pass, err_count, first_err_valid, first_err_vec
  );

  modport slave (
    output start, stop_on_err, dut_out,
    input  vec, busy, done, pass, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/sweep_checker.sv
// Exhaustive-stimulus engine: walks every WIDTH-bit vector, holds each HOLD cycles,
// samples the 1-bit DUT response on the last hold cycle and checks it against TRUTH.
module sweep_checker #(
  parameter int                     WIDTH = 2,
  parameter int                     HOLD  = 4,
  parameter logic [(1<<WIDTH)-1:0]  TRUTH = 4'b0110,
  parameter int                     ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  sweep_checker_if.master bus
);

  localparam int             HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_vec, w_vec_next;
  logic [HCW-1:0]   r_hold, w_hold_next;
  logic             r_stop_mode, w_stop_mode_next;
  logic [ERRW-1:0]  r_err_count, w_err_count_next;
  logic             r_first_valid, w_first_valid_next;
  logic [WIDTH-1:0] r_first_vec, w_first_vec_next;
  logic             r_pass, w_pass_next;
  logic             w_mismatch;

  assign w_mismatch = (bus.dut_out != TRUTH[r_vec]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vec         <= '0;
      r_hold        <= '0;
      r_stop_mode   <= 1'b0;
      r_err_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
      r_pass        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_vec         <= w_vec_next;
      r_hold        <= w_hold_next;
      r_stop_mode   <= w_stop_mode_next;
      r_err_count   <= w_err_count_next;
      r_first_valid <= w_first_valid_next;
      r_first_vec   <= w_first_vec_next;
      r_pass        <= w_pass_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_vec_next         = r_vec;
    w_hold_next        = r_hold;
    w_stop_mode_next   = r_stop_mode;
    w_err_count_next   = r_err_count;
    w_first_valid_next = r_first_valid;
    w_first_vec_next   = r_first_vec;
    w_pass_next        = r_pass;

    case (r_state)
      S_IDLE, S_DONE: begin
        // A new sweep always starts from a clean result set.
        if (bus.start) begin
          w_state_next       = S_RUN;
          w_vec_next         = '0;
          w_hold_next        = '0;
          w_stop_mode_next   = bus.stop_on_err;
          w_err_count_next   = '0;
          w_first_valid_next = 1'b0;
          w_first_vec_next   = '0;
          w_pass_next        = 1'b0;
        end
      end

      S_RUN: begin
        if (r_hold != HOLD_LAST) begin
          w_hold_next = r_hold + 1'b1;
        end else begin
          if (w_mismatch) begin
            if (r_err_count != {ERRW{1'b1}}) begin
              w_err_count_next = r_err_count + 1'b1;
            end
            if (!r_first_valid) begin
              w_first_valid_next = 1'b1;
              w_first_vec_next   = r_vec;
            end
          end

          // vec is left untouched on exit so it shows the failing or final vector.
          if (w_mismatch && r_stop_mode) begin
            w_state_next = S_DONE;
            w_pass_next  = 1'b0;
          end else if (r_vec == {WIDTH{1'b1}}) begin
            w_state_next = S_DONE;
            w_pass_next  = (w_err_count_next == '0);
          end else begin
            w_vec_next  = r_vec + 1'b1;
            w_hold_next = '0;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.vec             = r_vec;
  assign bus.busy            = (r_state == S_RUN);
  assign bus.done            = (r_state == S_DONE);
  assign bus.pass            = r_pass;
  assign bus.err_count       = r_err_count;
  assign bus.first_err_valid = r_first_valid;
  assign bus.first_err_vec   = r_first_vec;

endmodule

// File: tb/tb_sweep_checker.sv
// Directed bench for sweep_checker: a 2-bit XOR sweep with HOLD=4 and a 4-bit
// HOLD=1 sweep with a 2-bit saturating error counter.
module tb_sweep_checker;

  logic clk;
  logic rst;
  int   n_applied;
  int   n_miscompares;
  bit   dut_mode;   // 0 = XOR DUT, 1 = stuck-at-0 DUT

  sweep_checker_if #(.WIDTH(2), .ERRW(8)) ifa ();
  sweep_checker_if #(.WIDTH(4), .ERRW(2)) ifb ();

  sweep_checker #(.WIDTH(2), .HOLD(4), .TRUTH(4'b0110), .ERRW(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  sweep_checker #(.WIDTH(4), .HOLD(1), .TRUTH(16'hFFFF), .ERRW(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  assign ifa.dut_out = dut_mode ? 1'b0 : (ifa.vec[0] ^ ifa.vec[1]);
  assign ifb.dut_out = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles on ifa; optionally checks the vector walk; bounded.
  task automatic wait_sweep_a(input bit chk_vec, output int cyc);
    cyc = 0;
    while (ifa.busy && cyc < 200) begin
      if (chk_vec) check("a_vec_walk", 32'(ifa.vec), 32'(cyc / 4));
      check("a_pass_low_busy", 32'(ifa.pass), 32'd0);
      cyc++;
      tick();
    end
    check("a_sweep_ended", 32'(ifa.busy), 32'd0);
  endtask

  task automatic check_a_results(input string tag, input int cyc, input int exp_cyc,
                                 input int err, input bit fvalid, input int fvec,
                                 input bit pass, input int vec);
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_done"}, 32'(ifa.done), 32'd1);
    check({tag, "_pass"}, 32'(ifa.pass), 32'(pass));
    check({tag, "_err_count"}, 32'(ifa.err_count), 32'(err));
    check({tag, "_first_valid"}, 32'(ifa.first_err_valid), 32'(fvalid));
    check({tag, "_first_vec"}, 32'(ifa.first_err_vec), 32'(fvec));
    check({tag, "_vec"}, 32'(ifa.vec), 32'(vec));
  endtask

  initial begin
    int cyc;
    n_applied     = 0;
    n_miscompares = 0;
    dut_mode      = 1'b0;
    rst           = 1'b1;
    ifa.start = 1'b0; ifa.stop_on_err = 1'b0;
    ifb.start = 1'b0; ifb.stop_on_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_vec", 32'(ifa.vec), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_pass", 32'(ifa.pass), 32'd0);
    check("rst_err", 32'(ifa.err_count), 32'd0);
    check("rst_fvalid", 32'(ifa.first_err_valid), 32'd0);
    check("rst_fvec", 32'(ifa.first_err_vec), 32'd0);
    check("rst_b_busy", 32'(ifb.busy), 32'd0);

    // Clean XOR sweep
    dut_mode = 1'b0;
    ifa.start = 1'b1; ifa.stop_on_err = 1'b0;
    tick();
    ifa.start = 1'b0;
    check("xor_busy_after_start", 32'(ifa.busy), 32'd1);
    wait_sweep_a(1'b1, cyc);
    check_a_results("xor", cyc, 16, 0, 1'b0, 0, 1'b1, 3);

    // Stuck-at-0, no early stop
    dut_mode = 1'b1;
    ifa.start = 1'b1; ifa.stop_on_err = 1'b0;
    tick();
    ifa.start = 1'b0;
    wait_sweep_a(1'b0, cyc);
    check_a_results("sa0", cyc, 16, 2, 1'b1, 1, 1'b0, 3);

    // Stuck-at-0, stop on first error; restart from DONE clears results
    ifa.start = 1'b1; ifa.stop_on_err = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.stop_on_err = 1'b0;
    check("restart_err_cleared", 32'(ifa.err_count), 32'd0);
    check("restart_fvalid_cleared", 32'(ifa.first_err_valid), 32'd0);
    check("restart_done_cleared", 32'(ifa.done), 32'd0);
    check("restart_vec", 32'(ifa.vec), 32'd0);
    wait_sweep_a(1'b0, cyc);
    check_a_results("sa0_stop", cyc, 8, 1, 1'b1, 1, 1'b0, 1);

    // start held high across the whole sweep
    dut_mode = 1'b0;
    ifa.start = 1'b1; ifa.stop_on_err = 1'b0;
    tick();
    wait_sweep_a(1'b1, cyc);
    check_a_results("held", cyc, 16, 0, 1'b0, 0, 1'b1, 3);
    // start still high in DONE -> restart next edge
    tick();
    check("held_restart_busy", 32'(ifa.busy), 32'd1);
    check("held_restart_vec", 32'(ifa.vec), 32'd0);
    check("held_restart_done", 32'(ifa.done), 32'd0);
    check("held_restart_pass", 32'(ifa.pass), 32'd0);

    // Mid-sweep reset (with start also high: reset wins)
    repeat (9) tick();
    check("mid_vec_before_rst", 32'(ifa.vec), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifa.start = 1'b0;
    check("mid_rst_vec", 32'(ifa.vec), 32'd0);
    check("mid_rst_busy", 32'(ifa.busy), 32'd0);
    check("mid_rst_done", 32'(ifa.done), 32'd0);
    check("mid_rst_err", 32'(ifa.err_count), 32'd0);
    tick();
    check("idle_stays_idle", 32'(ifa.busy), 32'd0);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    wait_sweep_a(1'b1, cyc);
    check_a_results("post_rst", cyc, 16, 0, 1'b0, 0, 1'b1, 3);

    // WIDTH=4, HOLD=1, ERRW=2, all-ones truth, DUT tied low
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    cyc = 0;
    while (ifb.busy && cyc < 200) begin
      check("b_vec_walk", 32'(ifb.vec), 32'(cyc));
      cyc++;
      tick();
    end
    check("b_sweep_ended", 32'(ifb.busy), 32'd0);
    check("b_busy_cycles", 32'(cyc), 32'd16);
    check("b_done", 32'(ifb.done), 32'd1);
    check("b_err_sat", 32'(ifb.err_count), 32'd3);
    check("b_fvalid", 32'(ifb.first_err_valid), 32'd1);
    check("b_fvec", 32'(ifb.first_err_vec), 32'd0);
    check("b_pass", 32'(ifb.pass), 32'd0);
    check("b_vec_final", 32'(ifb.vec), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
